// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: request, ALU-drive and response signal bundle for alu_req_arbiter
interface alu_req_arbiter_if #(parameter int N = 8);
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]   req0_op, req1_op;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic [4:0]   alu_op;
    logic [N-1:0] alu_a, alu_b, alu_res;
    logic         alu_cin, alu_v, alu_c, alu_n, alu_z;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_data;
    logic [3:0]   rsp_flags;
    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, alu_res, alu_v, alu_c, alu_n, alu_z, rsp_ready,
        output req0_ready, req1_ready, alu_op, alu_a, alu_b, alu_cin,
               rsp_valid, rsp_id, rsp_data, rsp_flags
    );
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, alu_res, alu_v, alu_c, alu_n, alu_z, rsp_ready,
        input  req0_ready, req1_ready, alu_op, alu_a, alu_b, alu_cin,
               rsp_valid, rsp_id, rsp_data, rsp_flags
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sequencer sharing one combinational ALU between two requesters
module alu_req_arbiter #(parameter int N = 8) (
    input logic clk,
    input logic reset,
    alu_req_arbiter_if.slave bus
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
    state_t r_state, w_next;
    logic r_last, r_id, r_rsp_valid, r_alu_cin;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0] r_a, r_b, r_alu_a, r_alu_b, r_rsp_data;
    logic [4:0] r_alu_op, w_op;
    logic [3:0] r_rsp_flags;
    logic [N-1:0] w_a, w_b;
    logic w_gnt, w_cin, w_mul, w_acc, w_last_mul, w_ready0, w_ready1;
    assign w_gnt = bus.req0_valid & bus.req1_valid ? ~r_last : bus.req1_valid;
    assign w_op = w_gnt ? bus.req1_op : bus.req0_op;
    assign w_a = w_gnt ? bus.req1_a : bus.req0_a;
    assign w_b = w_gnt ? bus.req1_b : bus.req0_b;
    assign w_cin = w_gnt ? bus.req1_cin : bus.req0_cin;
    assign w_mul = w_op == 5'd2;
    assign w_acc = w_ready0 | w_ready1;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_last_mul = r_cnt == CW'(N - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    always_comb begin
        w_next = r_state;
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready0 = ~reset & bus.req0_valid & ~w_gnt;
                w_ready1 = ~reset & bus.req1_valid & w_gnt;
                if (w_ready0 | w_ready1)
                    w_next = w_mul ? MUL : EXEC;
            end
            EXEC: w_next = RESP;
            MUL:  w_next = w_last_mul ? RESP : MUL;
            RESP: w_next = bus.rsp_ready ? IDLE : RESP;
        endcase
    end
    // MUL reuses r_alu_a as the accumulator; r_alu_b carries the next partial product
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_last <= 1'b1;
            r_id <= 1'b0;
            r_a <= '0;
            r_b <= '0;
            r_cnt <= '0;
            r_alu_op <= '0;
            r_alu_a <= '0;
            r_alu_b <= '0;
            r_alu_cin <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_flags <= '0;
        end else begin
            if (w_acc) begin
                r_last <= w_gnt;
                r_id <= w_gnt;
                r_a <= w_a;
                r_b <= w_b;
                r_cnt <= '0;
                r_alu_op <= w_mul ? 5'd0 : w_op;
                r_alu_a <= w_mul ? '0 : w_a;
                r_alu_b <= w_mul ? (w_b[0] ? w_a : '0) : w_b;
                r_alu_cin <= ~w_mul & w_cin;
            end
            if (r_state == MUL) begin
                r_cnt <= w_cnt_nxt;
                r_alu_a <= bus.alu_res;
                r_alu_b <= r_b[w_cnt_nxt] ? r_a << w_cnt_nxt : '0;
            end
            if (r_state == EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data <= bus.alu_res;
                r_rsp_flags <= {bus.alu_v, bus.alu_c, bus.alu_n, bus.alu_z};
            end else if (r_state == MUL && w_last_mul) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data <= bus.alu_res;
                r_rsp_flags <= {2'b00, bus.alu_res[N-1], bus.alu_res == '0};
            end else if (r_rsp_valid & bus.rsp_ready)
                r_rsp_valid <= 1'b0;
        end
    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.alu_op = r_alu_op;
    assign bus.alu_a = r_alu_a;
    assign bus.alu_b = r_alu_b;
    assign bus.alu_cin = r_alu_cin;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id = r_id;
    assign bus.rsp_data = r_rsp_data;
    assign bus.rsp_flags = r_rsp_flags;
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Sequencer and arbiter that shares the single combinational ALU between two requesters. Accepts operation requests over valid/ready handshakes with round-robin arbitration, drives the ALU's OpCode/operand/carry inputs from registers, captures result and V/C/N/Z_ flags, and returns them on a response channel with backpressure. The ALU's multiply opcode is stubbed, so the block also executes MUL as an N-cycle shift-and-add loop over the ALU's ADD path.

## Interface
- N, default 8: operand/result width.
- clk  in  1: sole clock, rising edge.
- reset  in  1: asynchronous, active-high; clears all state.
- req0_valid, req1_valid  in  1: request valid per port.
- req0_ready, req1_ready  out  1: request accepted this cycle when valid&ready.
- req0_op, req1_op  in  5: ALU opcode.
- req0_a, req0_b, req1_a, req1_b  in  N: operands.
- req0_cin, req1_cin  in  1: carry-in.
- alu_op  out  5: to ALU OpCode.
- alu_a, alu_b  out  N: to ALU a, b.
- alu_cin  out  1: to ALU cin.
- alu_res  in  N: from ALU alu_out.
- alu_v, alu_c, alu_n, alu_z  in  1: from ALU V, C, N, Z_.
- rsp_valid  out  1: response valid.
- rsp_ready  in  1: response consumer ready.
- rsp_id  out  1: port that issued the request.
- rsp_data  out  N: result.
- rsp_flags  out  4: {V, C, N, Z}.

## Operation
- States: IDLE, EXEC, MUL, RESP. Reset -> IDLE.
- IDLE: req_ready asserted only to the granted port, combinationally from state and grant; all other readys 0. Never two accepts in one cycle.
- Arbitration: round-robin on a 1-bit last-served pointer; reset value 1 so port 0 wins the first tie. If only one port valid it is granted. Pointer updates on each accept.
- Accept: latch op, a, b, cin, id. op == 5'd2 -> MUL; all others -> EXEC.
- EXEC (1 cycle): alu_op/alu_a/alu_b/alu_cin = latched values; capture alu_res and flags at end of cycle -> RESP.
- MUL: counter i 0..N-1, accumulator acc reset to 0 on entry. Each cycle alu_op = 5'd0, alu_a = acc, alu_b = b[i] ? (a << i) truncated to N : 0, alu_cin = 0; acc <= alu_res. After i = N-1 -> RESP. Result = low N bits of a*b. Flags: V = 0, C = 0, N = result[N-1], Z = (result == 0).
- Non-MUL opcodes pass through unmodified; DIV (5'd3) returns whatever the ALU yields (0) with captured flags.
- RESP: rsp_valid = 1, outputs held stable until rsp_ready; on valid&ready -> IDLE. No new request accepted while in EXEC/MUL/RESP.
- Outside EXEC/MUL, ALU drive outputs hold last values (no requirement on them).
- Reset mid-operation: all state discarded, no response produced.

## Timing
- Reset values: req0_ready = req1_ready = 0 while reset asserted; rsp_valid 0, rsp_id 0, rsp_data 0, rsp_flags 0, alu_op 0, alu_a 0, alu_b 0, alu_cin 0.
- Accept at edge t -> EXEC during cycle t+1 -> rsp_valid from t+2. Non-MUL latency 2 cycles.
- MUL: accept at t -> MUL cycles t+1..t+N -> rsp_valid from t+N+1.
- With rsp_ready held high, throughput is one op per 3 cycles (non-MUL), IDLE always spends at least one cycle.
- rsp_* registered; response data must not change while rsp_valid & !rsp_ready.

## Test plan
- Single ADD, port 0: op 0, a 8'h7F, b 8'h01, cin 0 -> rsp at t+2: data 8'h80, id 0, V 1, C 0, N 1, Z 0.
- Contention: both ports valid each cycle with SUB ops -> grants alternate 0,1,0,1; rsp_id sequence matches; no lost or duplicated requests over 20 ops.
- MUL: port 1, a 8'd13, b 8'd11 -> rsp at t+9: data 8'd143, flags V 0 C 0 N 1 Z 0; MUL 8'd16 x 8'd16 -> data 0, Z 1.
- Backpressure: rsp_ready low 5 cycles during RESP -> rsp_valid, data, flags, id stable; both req_ready stay 0; accept resumes the cycle after rsp handshake.
- Reset mid-MUL (cycle 4 of 8) -> next cycle rsp_valid 0, readys 0 until reset deasserts, then port 0 wins first tie.
- Passthrough: AND op 5'd4, a 8'hF0, b 8'h3C -> data 8'h30 with ALU-reported flags captured unchanged.
